// File: rtl/window_frame_ctrl.sv
// Frame sequencer for the Hamming windowing multiplier: buffers incoming samples
// in a circular frame store and replays each overlapping frame through the multiplier.
module window_frame_ctrl #(
   parameter int FRAME_LEN = 256,
   parameter int SHIFT     = 128,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [16:0]       in_sample,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [16:0]       win_sample,
   output logic              win_en,
   output logic [ADDR_W-2:0] coef_addr,
   input  logic [20:0]       win_result,
   output logic [20:0]       out_sample,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last,
   output logic [15:0]       frame_cnt,
   output logic              busy,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_FILL  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CAPT  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] SHIFT_M   = ADDR_W'(SHIFT % FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_N    = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(FRAME_LEN);
   localparam logic [ADDR_W:0]   SHIFT_CNT = (ADDR_W+1)'(SHIFT);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // a producer holds valid and data stable until that edge.

   state_t              r_state;
   logic [16:0]         r_buf [FRAME_LEN];
   logic [ADDR_W-1:0]   r_wp;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_n;
   logic [ADDR_W:0]     r_new_cnt;
   logic                r_first;
   logic                r_in_ready;
   logic [16:0]         r_win_sample;
   logic                r_win_en;
   logic [ADDR_W-2:0]   r_coef_addr;
   logic [20:0]         r_out_sample;
   logic                r_out_valid;
   logic                r_out_first;
   logic                r_out_last;
   logic [15:0]         r_frame_cnt;

   logic                w_accept;
   logic [ADDR_W:0]     w_target;
   logic                w_fill_done;
   logic [ADDR_W-1:0]   w_n_next;
   logic [ADDR_W-1:0]   w_rd_idx;
   logic [ADDR_W-2:0]   w_coef_next;

   assign w_accept    = in_valid && r_in_ready;
   assign w_target    = r_first ? FULL_CNT : SHIFT_CNT;
   assign w_fill_done = w_accept && ((r_new_cnt + (ADDR_W+1)'(1)) == w_target);
   // Index of the sample being issued next: 0 when leaving FILL, n+1 when leaving HOLD.
   assign w_n_next    = (r_state == S_HOLD) ? r_n + ADDR_W'(1) : '0;
   assign w_rd_idx    = r_base + w_n_next;
   // Mirrored half-window address: for n >= FRAME_LEN/2, FRAME_LEN-1-n equals ~n.
   assign w_coef_next = w_n_next[ADDR_W-1] ? ~w_n_next[ADDR_W-2:0] : w_n_next[ADDR_W-2:0];

   always_ff @(posedge clk) begin
      if (w_accept && !flush) begin
         r_buf[r_wp] <= in_sample;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_FILL;
         r_wp         <= '0;
         r_base       <= '0;
         r_n          <= '0;
         r_new_cnt    <= '0;
         r_first      <= 1'b1;
         r_in_ready   <= 1'b0;
         r_win_sample <= '0;
         r_win_en     <= 1'b0;
         r_coef_addr  <= '0;
         r_out_sample <= '0;
         r_out_valid  <= 1'b0;
         r_out_first  <= 1'b0;
         r_out_last   <= 1'b0;
         r_frame_cnt  <= '0;
      end else if (flush) begin
         r_state     <= S_FILL;
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_win_en    <= 1'b0;
         r_new_cnt   <= '0;
         r_n         <= '0;
         r_base      <= r_wp;
         r_first     <= 1'b1;
         r_in_ready  <= 1'b1;
      end else begin
         r_win_en <= 1'b0;
         case (r_state)
            S_FILL: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_wp <= r_wp + ADDR_W'(1);
                  if (w_fill_done) begin
                     r_new_cnt    <= '0;
                     r_first      <= 1'b0;
                     r_in_ready   <= 1'b0;
                     r_n          <= '0;
                     r_win_en     <= 1'b1;
                     r_win_sample <= r_buf[w_rd_idx];
                     r_coef_addr  <= w_coef_next;
                     r_state      <= S_ISSUE;
                  end else begin
                     r_new_cnt <= r_new_cnt + (ADDR_W+1)'(1);
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT:  r_state <= S_CAPT;
            S_CAPT: begin
               r_out_sample <= win_result;
               r_out_valid  <= 1'b1;
               r_out_first  <= (r_n == '0);
               r_out_last   <= (r_n == LAST_N);
               r_state      <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_n != LAST_N) begin
                     r_n          <= w_n_next;
                     r_win_en     <= 1'b1;
                     r_win_sample <= r_buf[w_rd_idx];
                     r_coef_addr  <= w_coef_next;
                     r_state      <= S_ISSUE;
                  end else begin
                     r_base      <= r_base + SHIFT_M;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                     r_in_ready  <= 1'b1;
                     r_state     <= S_FILL;
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign win_sample = r_win_sample;
   assign win_en     = r_win_en;
   assign coef_addr  = r_coef_addr;
   assign out_sample = r_out_sample;
   assign out_valid  = r_out_valid;
   assign out_first  = r_out_first;
   assign out_last   = r_out_last;
   assign frame_cnt  = r_frame_cnt;
   assign busy       = (r_state != S_FILL);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_window_frame_ctrl.sv
// Scoreboard bench for window_frame_ctrl with an 8-sample frame, hop 4, and a
// 2-cycle multiplier model fed by a coef = addr+1 ROM.
module tb_window_frame_ctrl;

   localparam int FL = 8;
   localparam int SH = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic [16:0]   in_sample = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [16:0]   win_sample;
   logic          win_en;
   logic [AW-2:0] coef_addr;
   logic [20:0]   win_result = '0;
   logic [20:0]   out_sample;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_first;
   logic          out_last;
   logic [15:0]   frame_cnt;
   logic          busy;
   logic [2:0]    dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   window_frame_ctrl #(.FRAME_LEN(FL), .SHIFT(SH), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
      .win_sample(win_sample), .win_en(win_en), .coef_addr(coef_addr),
      .win_result(win_result),
      .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last),
      .frame_cnt(frame_cnt), .busy(busy), .dbg_state(dbg_state)
   );

   // Multiplier model: operands captured on the edge that sees win_en, product one edge later.
   logic               m_pend = 1'b0;
   logic signed [20:0] m_a = '0;
   logic signed [20:0] m_c = '0;
   always @(posedge clk) begin
      m_pend <= win_en;
      if (win_en) begin
         m_a <= 21'($signed(win_sample));
         m_c <= 21'(coef_addr) + 21'sd1;
      end
      if (m_pend) win_result <= 21'(m_a * m_c);
   end

   // ---------------- scoreboard ----------------
   logic [22:0]   exp_q[$];
   logic [AW-2:0] exp_coef_q[$];
   int            hist[$];
   bit            m_first = 1'b1;
   int            m_new = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            out_idx = 0;
   int            last_en = -100;
   bit            measure = 1'b0;
   int            en_cycles[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_accept(input int v);
      hist.push_back(v);
      m_new++;
      if (m_new == (m_first ? FL : SH)) begin
         m_new   = 0;
         m_first = 1'b0;
         for (int i = 0; i < FL; i++) begin
            int          s;
            int          c;
            logic [22:0] e;
            s = hist[hist.size() - FL + i];
            c = (i < FL/2) ? i + 1 : FL - i;
            e = {(i == 0), (i == FL-1), 21'(s * c)};
            exp_q.push_back(e);
            exp_coef_q.push_back((AW-1)'((i < FL/2) ? i : FL - 1 - i));
         end
      end
   endtask

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
      exp_coef_q.delete();
      m_first = 1'b1;
      m_new   = 0;
      out_idx = 0;
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         if (busy) chk("in_ready_busy", 32'(in_ready), 0);
         if (win_en) begin
            chk("en_gap_min", 32'((cyc - last_en) >= 3), 1);
            last_en = cyc;
            if (measure) en_cycles.push_back(cyc);
            if (exp_coef_q.size() == 0) chk("coef_unexpected", 1, 0);
            else chk("coef_addr", 32'(coef_addr), 32'(exp_coef_q.pop_front()));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
            else chk("out_word", 32'({out_first, out_last, out_sample}), 32'(exp_q.pop_front()));
            out_idx = out_last ? 0 : out_idx + 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_sample(input int v);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      in_sample = 17'(v);
      in_valid  = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (acc) model_accept(v);
      else chk("push_timeout", 0, 1);
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frame_cnt != 16'(target) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("frame_cnt", 32'(frame_cnt), 32'(target));
   endtask

   task automatic wait_idx(input int k);
      int n;
      n = 0;
      while (out_idx != k && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_idx", 32'(out_idx), 32'(k));
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_valid", 32'(out_valid), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, 32'({in_ready, win_en, out_valid, out_first, out_last, busy}), 0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
      chk({tag, "_out_sample"}, 32'(out_sample), 0);
      chk({tag, "_win_sample"}, 32'(win_sample), 0);
      chk({tag, "_coef"}, 32'(coef_addr), 0);
      chk({tag, "_state"}, 32'(dbg_state), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_fill", 32'(in_ready), 1);

      // Frame 1 with a 10-cycle stall on output index 3
      for (int v = 1; v <= 8; v++) push_sample(v);
      @(negedge clk);
      chk("in_ready_after_last", 32'(in_ready), 0);
      @(posedge clk); #1;
      wait_idx(3);
      out_ready = 1'b0;
      wait_valid();
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_sample", 32'(out_sample), 16);
         chk("stall_no_en", 32'(win_en), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_frames(1);
      chk("in_ready_refill", 32'(in_ready), 1);

      // Frame 2: overlap with hop 4, and win_en spacing with out_ready high
      en_cycles.delete();
      measure = 1'b1;
      for (int v = 9; v <= 12; v++) push_sample(v);
      wait_frames(2);
      measure = 1'b0;
      chk("en_count", 32'(en_cycles.size()), 8);
      for (int i = 1; i < en_cycles.size(); i++)
         chk("en_spacing", 32'(en_cycles[i] - en_cycles[i-1]), 4);

      // Frame 3 aborted by flush while output index 5 is held
      for (int v = 13; v <= 16; v++) push_sample(v);
      wait_idx(5);
      out_ready = 1'b0;
      wait_valid();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      model_reset();
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_win_en", 32'(win_en), 0);
      chk("flush_busy", 32'(busy), 0);
      chk("flush_frame_cnt", 32'(frame_cnt), 2);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // After flush a full frame of new samples is needed
      for (int v = 20; v <= 26; v++) push_sample(v);
      repeat (6) @(posedge clk);
      #1;
      chk("seven_no_start", 32'(busy), 0);
      chk("seven_frame_cnt", 32'(frame_cnt), 2);
      push_sample(27);
      wait_frames(3);

      // Frame 5 interrupted by async reset during WAIT
      for (int v = 30; v <= 33; v++) push_sample(v);
      n = 0;
      while (!win_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("saw_issue", 32'(win_en), 1);
      @(posedge clk); #1;
      chk("in_wait", 32'(dbg_state), 2);
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      last_en = -100;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Same as the first frame after reset release
      for (int v = 1; v <= 8; v++) push_sample(v);
      wait_frames(1);
      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_empty", 32'(exp_q.size()), 0);
      chk("coef_q_empty", 32'(exp_coef_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
